des_perm_pipe: RTL and testbench

- Parametrised, pipelined DES bit-permutation unit; generalises the fixed combinational initial/final permutations.
- Handles LANES independent 64-bit blocks per transfer, with a per-transfer mode: IP, IP^-1, pass, or swap-then-IP^-1.
- Elastic valid/ready pipeline sits between key-schedule/round cores and the result comparator.
- Carries a sideband tag so candidate indices stay aligned with their data.

---
 rtl/des_perm_pkg.sv | 66 ++++++
 rtl/des_perm_pipe_if.sv | 35 +++
 rtl/des_perm_lane.sv | 21 ++
 rtl/des_perm_pipe.sv | 106 ++++++++++
 tb/tb_des_perm_pipe.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_perm_pkg.sv
// Shared definitions for the DES permutation pipeline: the mode encodings and
// the FIPS 46-3 IP / IP^-1 tables with the functions that apply them.
package des_perm_pkg;

  localparam logic [1:0] MODE_IP      = 2'b00;
  localparam logic [1:0] MODE_FP      = 2'b01;
  localparam logic [1:0] MODE_PASS    = 2'b10;
  localparam logic [1:0] MODE_SWAP_FP = 2'b11;

  typedef logic [63:0] des_block_t;

  // Entry n is the FIPS input bit (1 = MSB) that feeds FIPS output bit n+1.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  // FIPS bit b lives at vector index 64-b, so output bit n+1 is index 63-n.
  function automatic des_block_t des_ip(input des_block_t din);
    des_block_t dout;
    logic [5:0] dst;
    logic [5:0] src;
    dout = '0;
    for (int n = 0; n < 64; n++) begin
      dst = 6'(63 - n);
      src = 6'(64 - IP_TBL[6'(n)]);
      dout[dst] = din[src];
    end
    return dout;
  endfunction

  function automatic des_block_t des_fp(input des_block_t din);
    des_block_t dout;
    logic [5:0] dst;
    logic [5:0] src;
    dout = '0;
    for (int n = 0; n < 64; n++) begin
      dst = 6'(63 - n);
      src = 6'(64 - FP_TBL[6'(n)]);
      dout[dst] = din[src];
    end
    return dout;
  endfunction

  function automatic des_block_t des_swap(input des_block_t din);
    return {din[31:0], din[63:32]};
  endfunction

endpackage

// File: rtl/des_perm_pipe_if.sv
// Upstream/downstream bundle of the DES permutation pipeline.
interface des_perm_pipe_if #(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
);
  localparam int DATA_W = 64 * LANES;
  localparam int CNT_W  = $clog2(STAGES + 1);

  // A transfer happens on a rising edge where valid && ready; the sender holds
  // mode/tag/data stable while valid is high and ready is low, and ready may
  // depend combinationally on the downstream ready.
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_mode;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  inflight;

  modport master (
    output in_valid, in_mode, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_tag, out_data, inflight
  );

  modport slave (
    input  in_valid, in_mode, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_tag, out_data, inflight
  );

endinterface

// File: rtl/des_perm_lane.sv
// One 64-bit lane of permutation wiring; the mode picks IP, IP^-1, pass or
// IP^-1 of the half-swapped word (the R16||L16 output step).
module des_perm_lane
  import des_perm_pkg::*;
(
  input  logic [1:0] mode,
  input  des_block_t din,
  output des_block_t dout
);

  always_comb begin
    dout = din;
    case (mode)
      MODE_IP:      dout = des_ip(din);
      MODE_FP:      dout = des_fp(din);
      MODE_PASS:    dout = din;
      MODE_SWAP_FP: dout = des_fp(des_swap(din));
    endcase
  end

endmodule

// File: rtl/des_perm_pipe.sv
// Elastic DES permutation pipeline: LANES parallel permutations in front of
// STAGES collapsing register stages carrying mode and tag alongside the data.
module des_perm_pipe
  import des_perm_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic           CLK,
  input  logic           RST,
  des_perm_pipe_if.slave bus
);

  localparam int DATA_W = 64 * LANES;
  localparam int CNT_W  = $clog2(STAGES + 1);
  localparam int SI_W   = (STAGES > 1) ? $clog2(STAGES) : 1;

  if (STAGES < 1) begin : g_bad_stages
    $error("des_perm_pipe: STAGES must be at least 1");
  end

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][1:0]        mode_q,  mode_d;
  logic [STAGES-1:0][TAG_W-1:0]  tag_q,   tag_d;
  logic [STAGES-1:0][DATA_W-1:0] data_q,  data_d;
  logic [STAGES-1:0]             stage_ready;
  logic [DATA_W-1:0]             perm_data;
  logic [CNT_W-1:0]              inflight_cnt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    des_perm_lane u_lane (
      .mode (bus.in_mode),
      .din  (bus.in_data[64*k +: 64]),
      .dout (perm_data[64*k +: 64])
    );
  end

  // A stage can load when it is empty or anything downstream can move, so
  // bubbles are squeezed out even while the output is stalled.
  always_comb begin : ready_chain
    logic rdy;
    rdy         = bus.out_ready;
    stage_ready = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy                    = rdy | ~valid_q[SI_W'(i)];
      stage_ready[SI_W'(i)] = rdy;
    end
  end

  always_comb begin : next_state
    valid_d = valid_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (stage_ready[0]) begin
      valid_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        mode_d[0] = bus.in_mode;
        tag_d[0]  = bus.in_tag;
        data_d[0] = perm_data;
      end
    end
    for (int i = 1; i < STAGES; i++) begin
      if (stage_ready[SI_W'(i)]) begin
        valid_d[SI_W'(i)] = valid_q[SI_W'(i - 1)];
        if (valid_q[SI_W'(i - 1)]) begin
          mode_d[SI_W'(i)] = mode_q[SI_W'(i - 1)];
          tag_d[SI_W'(i)]  = tag_q[SI_W'(i - 1)];
          data_d[SI_W'(i)] = data_q[SI_W'(i - 1)];
        end
      end
    end
  end

  always_comb begin : occupancy
    inflight_cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(valid_q[SI_W'(i)]);
    end
  end

  // Reset discards every in-flight word and clears the payload too, so the
  // outputs read as zero while the pipeline is empty after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = stage_ready[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_mode  = mode_q[STAGES-1];
  assign bus.out_tag   = tag_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];
  assign bus.inflight  = inflight_cnt;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe: three instances cover LANES=1/STAGES=2,
// LANES=4/STAGES=2 and LANES=1/STAGES=3.
module tb_des_perm_pipe;
  import des_perm_pkg::*;

  logic CLK;
  logic RST;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [63:0] stream_in[$];
  logic [63:0] stream_out[$];

  des_perm_pipe_if #(.LANES(1), .STAGES(2), .TAG_W(8)) if_a ();
  des_perm_pipe_if #(.LANES(4), .STAGES(2), .TAG_W(8)) if_b ();
  des_perm_pipe_if #(.LANES(1), .STAGES(3), .TAG_W(8)) if_c ();

  des_perm_pipe #(.LANES(1), .STAGES(2), .TAG_W(8)) u_a (.CLK(CLK), .RST(RST), .bus(if_a));
  des_perm_pipe #(.LANES(4), .STAGES(2), .TAG_W(8)) u_b (.CLK(CLK), .RST(RST), .bus(if_b));
  des_perm_pipe #(.LANES(1), .STAGES(3), .TAG_W(8)) u_c (.CLK(CLK), .RST(RST), .bus(if_c));

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic drive_idle();
    if_a.in_valid = 0; if_a.in_mode = 0; if_a.in_tag = 0; if_a.in_data = 0; if_a.out_ready = 1;
    if_b.in_valid = 0; if_b.in_mode = 0; if_b.in_tag = 0; if_b.in_data = 0; if_b.out_ready = 1;
    if_c.in_valid = 0; if_c.in_mode = 0; if_c.in_tag = 0; if_c.in_data = 0; if_c.out_ready = 1;
  endtask

  // One word into an idle instance A; reports out_valid one cycle early and
  // the output seen in the cycle where it is due.
  task automatic xfer_a(input logic [1:0] mode, input logic [63:0] data, input logic [7:0] tag,
                        output logic early_v, output logic v, output logic [63:0] d,
                        output logic [7:0] t, output logic [1:0] m);
    @(posedge CLK); #1;
    if_a.in_valid = 1; if_a.in_mode = mode; if_a.in_data = data; if_a.in_tag = tag;
    @(posedge CLK); #1;
    if_a.in_valid = 0;
    @(negedge CLK);
    early_v = if_a.out_valid;
    @(negedge CLK);
    v = if_a.out_valid; d = if_a.out_data; t = if_a.out_tag; m = if_a.out_mode;
  endtask

  task automatic stream_a(input logic [1:0] mode, output int got);
    int n;
    int got_l;
    n = stream_in.size();
    got_l = 0;
    stream_out.delete();
    fork
      begin
        @(posedge CLK); #1;
        for (int i = 0; i < n; i++) begin
          if_a.in_valid = 1; if_a.in_mode = mode; if_a.in_data = stream_in[i]; if_a.in_tag = 8'(i);
          @(posedge CLK); #1;
        end
        if_a.in_valid = 0;
      end
      begin
        int cyc;
        cyc = 0;
        while (got_l < n && cyc < n + 20) begin
          @(negedge CLK);
          cyc++;
          if (if_a.out_valid) begin
            stream_out.push_back(if_a.out_data);
            got_l++;
          end
        end
      end
    join
    got = got_l;
  endtask

  // tests
  task automatic test_reset();
    #12;
    n_cmp++; if (if_a.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_out_valid: got %b want 0", if_a.out_valid); end
    n_cmp++; if (if_a.inflight !== 2'd0) begin n_err++; $display("FAIL reset_a_inflight: got %0d want 0", if_a.inflight); end
    n_cmp++; if (if_a.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_a_in_ready: got %b want 1", if_a.in_ready); end
    n_cmp++; if (if_a.out_data !== 64'h0) begin n_err++; $display("FAIL reset_a_out_data: got %h want 0", if_a.out_data); end
    n_cmp++; if (if_a.out_tag !== 8'h0) begin n_err++; $display("FAIL reset_a_out_tag: got %h want 0", if_a.out_tag); end
    n_cmp++; if (if_a.out_mode !== 2'b00) begin n_err++; $display("FAIL reset_a_out_mode: got %b want 0", if_a.out_mode); end
    n_cmp++; if (if_b.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_out_valid: got %b want 0", if_b.out_valid); end
    n_cmp++; if (if_b.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_b_in_ready: got %b want 1", if_b.in_ready); end
    n_cmp++; if (if_c.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_c_out_valid: got %b want 0", if_c.out_valid); end
    n_cmp++; if (if_c.inflight !== 2'd0) begin n_err++; $display("FAIL reset_c_inflight: got %0d want 0", if_c.inflight); end
    RST = 0;
  endtask

  task automatic test_known_answer();
    logic [1:0]  md[4];
    logic [63:0] din[4];
    logic [63:0] exp_d[4];
    logic ev, v;
    logic [63:0] d;
    logic [7:0]  t;
    logic [1:0]  m;
    md    = '{MODE_IP, MODE_FP, MODE_SWAP_FP, MODE_PASS};
    din   = '{64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA, 64'hF0AAF0AACC00CCFF, 64'h0123456789ABCDEF};
    exp_d = '{64'hCC00CCFFF0AAF0AA, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    for (int i = 0; i < 4; i++) begin
      xfer_a(md[i], din[i], 8'(8'h10 + i), ev, v, d, t, m);
      n_cmp++; if (ev !== 1'b0) begin n_err++; $display("FAIL kat%0d_early_valid: got %b want 0", i, ev); end
      n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL kat%0d_valid: got %b want 1", i, v); end
      n_cmp++; if (d !== exp_d[i]) begin n_err++; $display("FAIL kat%0d_data: got %h want %h", i, d, exp_d[i]); end
      n_cmp++; if (t !== 8'(8'h10 + i)) begin n_err++; $display("FAIL kat%0d_tag: got %h want %h", i, t, 8'(8'h10 + i)); end
      n_cmp++; if (m !== md[i]) begin n_err++; $display("FAIL kat%0d_mode: got %b want %b", i, m, md[i]); end
    end
  endtask

  task automatic test_single_bit();
    logic ev, v;
    logic [63:0] d;
    logic [7:0]  t;
    logic [1:0]  m;
    xfer_a(MODE_IP, 64'h0000000000000040, 8'h21, ev, v, d, t, m);
    n_cmp++; if (v !== 1'b1 || d !== 64'h8000000000000000) begin n_err++; $display("FAIL bit_ip: got v=%b %h want v=1 8000000000000000", v, d); end
    xfer_a(MODE_FP, 64'h8000000000000000, 8'h22, ev, v, d, t, m);
    n_cmp++; if (v !== 1'b1 || d !== 64'h0000000000000040) begin n_err++; $display("FAIL bit_fp: got v=%b %h want v=1 0000000000000040", v, d); end
  endtask

  task automatic test_random();
    logic [63:0] exp_q[$];
    logic [63:0] e;
    int got;
    stream_in.delete();
    for (int i = 0; i < 1000; i++) stream_in.push_back({$urandom, $urandom});
    exp_q = stream_in;
    stream_a(MODE_IP, got);
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL rand_ip_count: got %0d want 1000", got); end
    stream_in = stream_out;
    stream_a(MODE_FP, got);
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL rand_fp_count: got %0d want 1000", got); end
    foreach (stream_out[i]) begin
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      n_cmp++; if (stream_out[i] !== e) begin n_err++; $display("FAIL rand_roundtrip[%0d]: got %h want %h", i, stream_out[i], e); end
    end
  endtask

  task automatic test_multi_lane();
    logic [63:0] exp_lane[4];
    logic [63:0] lane;
    exp_lane = '{64'hCC00CCFFF0AAF0AA, 64'h8000000000000000, 64'h0, 64'hFFFFFFFFFFFFFFFF};
    @(posedge CLK); #1;
    if_b.in_valid = 1; if_b.in_mode = MODE_IP; if_b.in_tag = 8'h5A;
    if_b.in_data = {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0000000000000040, 64'h0123456789ABCDEF};
    @(posedge CLK); #1;
    if_b.in_valid = 0;
    @(negedge CLK);
    n_cmp++; if (if_b.out_valid !== 1'b0) begin n_err++; $display("FAIL lanes_early_valid: got %b want 0", if_b.out_valid); end
    @(negedge CLK);
    n_cmp++; if (if_b.out_valid !== 1'b1) begin n_err++; $display("FAIL lanes_valid: got %b want 1", if_b.out_valid); end
    n_cmp++; if (if_b.out_tag !== 8'h5A) begin n_err++; $display("FAIL lanes_tag: got %h want 5a", if_b.out_tag); end
    for (int k = 0; k < 4; k++) begin
      lane = if_b.out_data[64*k +: 64];
      n_cmp++; if (lane !== exp_lane[k]) begin n_err++; $display("FAIL lane%0d_data: got %h want %h", k, lane, exp_lane[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_q[$];
    logic [7:0]  e;
    logic [7:0]  held_tag;
    logic [63:0] held_data;
    logic holding, resumed, stall_seen, full_seen;
    int got;
    holding = 0; resumed = 0; stall_seen = 0; full_seen = 0; got = 0;
    held_tag = 0; held_data = 0;
    for (int t = 1; t <= 10; t++) exp_q.push_back(8'(t));
    fork
      begin
        @(posedge CLK); #1;
        for (int t = 1; t <= 10; t++) begin
          int w;
          w = 0;
          if_c.in_valid = 1; if_c.in_mode = MODE_PASS; if_c.in_tag = 8'(t); if_c.in_data = {8{8'(t)}};
          @(negedge CLK);
          while (!if_c.in_ready && w < 50) begin @(negedge CLK); w++; end
          @(posedge CLK); #1;
        end
        if_c.in_valid = 0;
      end
      begin
        if_c.out_ready = 1;
        repeat (5) @(posedge CLK);
        #1 if_c.out_ready = 0;
        repeat (5) @(posedge CLK);
        #1 if_c.out_ready = 1;
      end
      begin
        int cyc;
        cyc = 0;
        while (got < 10 && cyc < 200) begin
          @(negedge CLK);
          cyc++;
          n_cmp++;
          if (if_c.in_ready !== !(if_c.inflight == 2'd3 && !if_c.out_ready)) begin
            n_err++; $display("FAIL bp_in_ready: got %b with inflight=%0d out_ready=%b", if_c.in_ready, if_c.inflight, if_c.out_ready);
          end
          if (if_c.inflight == 2'd3) full_seen = 1;
          if (stall_seen && if_c.out_ready) resumed = 1;
          if (if_c.out_valid && !if_c.out_ready) begin
            stall_seen = 1;
            if (holding) begin
              n_cmp++; if (if_c.out_tag !== held_tag || if_c.out_data !== held_data) begin
                n_err++; $display("FAIL bp_hold: got %h/%h want %h/%h", if_c.out_tag, if_c.out_data, held_tag, held_data);
              end
            end
            held_tag = if_c.out_tag; held_data = if_c.out_data; holding = 1;
          end else begin
            holding = 0;
          end
          if (resumed) begin
            n_cmp++; if (if_c.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_full_rate: got out_valid=%b want 1 after %0d words", if_c.out_valid, got); end
          end
          if (if_c.out_valid && if_c.out_ready) begin
            got++;
            if (exp_q.size() == 0) begin
              n_cmp++; n_err++; $display("FAIL bp_extra: got tag %h want none", if_c.out_tag);
            end else begin
              e = exp_q.pop_front();
              n_cmp++; if (if_c.out_tag !== e) begin n_err++; $display("FAIL bp_order: got tag %h want %h", if_c.out_tag, e); end
              n_cmp++; if (if_c.out_data !== {8{e}}) begin n_err++; $display("FAIL bp_data: got %h want %h", if_c.out_data, {8{e}}); end
            end
          end
        end
      end
    join
    n_cmp++; if (got != 10) begin n_err++; $display("FAIL bp_count: got %0d want 10", got); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    n_cmp++; if (full_seen !== 1'b1) begin n_err++; $display("FAIL bp_full: got %b want 1", full_seen); end
    n_cmp++; if (stall_seen !== 1'b1) begin n_err++; $display("FAIL bp_stall: got %b want 1", stall_seen); end
  endtask

  task automatic test_bubble_collapse();
    @(posedge CLK); #1;
    if_a.in_valid = 1; if_a.in_mode = MODE_PASS; if_a.in_tag = 8'h11; if_a.in_data = 64'h1111;
    @(posedge CLK); #1;
    if_a.in_valid = 0; if_a.out_ready = 0;
    @(posedge CLK); #1;
    if_a.in_valid = 1; if_a.in_mode = MODE_PASS; if_a.in_tag = 8'h22; if_a.in_data = 64'h2222;
    @(negedge CLK);
    n_cmp++; if (if_a.out_valid !== 1'b1 || if_a.out_tag !== 8'h11) begin n_err++; $display("FAIL bubble_first_held: got v=%b tag=%h want v=1 tag=11", if_a.out_valid, if_a.out_tag); end
    n_cmp++; if (if_a.in_ready !== 1'b1) begin n_err++; $display("FAIL bubble_in_ready: got %b want 1", if_a.in_ready); end
    n_cmp++; if (if_a.inflight !== 2'd1) begin n_err++; $display("FAIL bubble_inflight1: got %0d want 1", if_a.inflight); end
    @(posedge CLK); #1;
    if_a.in_valid = 0;
    @(negedge CLK);
    n_cmp++; if (if_a.inflight !== 2'd2) begin n_err++; $display("FAIL bubble_inflight2: got %0d want 2", if_a.inflight); end
    n_cmp++; if (if_a.out_tag !== 8'h11 || if_a.out_data !== 64'h1111) begin n_err++; $display("FAIL bubble_hold: got %h/%h want 11/1111", if_a.out_tag, if_a.out_data); end
    n_cmp++; if (if_a.in_ready !== 1'b0) begin n_err++; $display("FAIL bubble_full_ready: got %b want 0", if_a.in_ready); end
    @(posedge CLK); #1;
    if_a.out_ready = 1;
    @(negedge CLK);
    n_cmp++; if (if_a.out_valid !== 1'b1 || if_a.out_tag !== 8'h11) begin n_err++; $display("FAIL bubble_out1: got v=%b tag=%h want v=1 tag=11", if_a.out_valid, if_a.out_tag); end
    @(negedge CLK);
    n_cmp++; if (if_a.out_valid !== 1'b1 || if_a.out_tag !== 8'h22 || if_a.out_data !== 64'h2222) begin n_err++; $display("FAIL bubble_out2: got v=%b tag=%h want v=1 tag=22", if_a.out_valid, if_a.out_tag); end
    @(negedge CLK);
    n_cmp++; if (if_a.out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_drained: got %b want 0", if_a.out_valid); end
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    @(posedge CLK); #1;
    if_a.out_ready = 0;
    if_a.in_valid = 1; if_a.in_mode = MODE_IP; if_a.in_tag = 8'h33; if_a.in_data = 64'h0123456789ABCDEF;
    @(posedge CLK); #1;
    if_a.in_tag = 8'h44;
    @(posedge CLK); #1;
    if_a.in_valid = 0;
    @(negedge CLK);
    n_cmp++; if (if_a.inflight !== 2'd2) begin n_err++; $display("FAIL rstmid_pre_inflight: got %0d want 2", if_a.inflight); end
    #2 RST = 1;
    #1;
    n_cmp++; if (if_a.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", if_a.out_valid); end
    n_cmp++; if (if_a.inflight !== 2'd0) begin n_err++; $display("FAIL rstmid_inflight: got %0d want 0", if_a.inflight); end
    n_cmp++; if (if_a.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", if_a.in_ready); end
    n_cmp++; if (if_a.out_data !== 64'h0 || if_a.out_tag !== 8'h0) begin n_err++; $display("FAIL rstmid_payload: got %h/%h want 0/0", if_a.out_tag, if_a.out_data); end
    #1 RST = 0;
    if_a.out_ready = 1;
    repeat (6) begin
      @(negedge CLK);
      if (if_a.out_valid !== 1'b0) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL rstmid_stale: got %0d valid cycles want 0", stale); end
  endtask

  initial begin
    RST = 1;
    drive_idle();
    test_reset();
    test_known_answer();
    test_single_bit();
    test_random();
    test_multi_lane();
    test_back_to_back();
    test_bubble_collapse();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
